// File: rtl/pipelined_array_divider.sv
// Restoring array divider, one quotient bit resolved per stage.
// The last stage is the registered output stage; it holds its result through bubbles and stalls.
module pipelined_array_divider #(
  parameter int unsigned DW = 8,
  parameter int unsigned VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          in_valid,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  localparam int unsigned RW = VW + 1;
  localparam int unsigned TW = VW + 2;
  localparam int unsigned NS = DW - 1;

  // Intermediate stage registers; stage DW-1 is the output register set.
  logic          vld_q [NS];
  logic [RW-1:0] rem_q [NS];
  logic [DW-1:0] dvd_q [NS];
  logic [DW-1:0] quo_q [NS];
  logic [VW-1:0] dvs_q [NS];
  logic          dz_q  [NS];

  // Per-stage operands (from input or previous stage) and next-state values.
  logic          src_vld [DW];
  logic [RW-1:0] src_rem [DW];
  logic [DW-1:0] src_dvd [DW];
  logic [DW-1:0] src_quo [DW];
  logic [VW-1:0] src_dvs [DW];
  logic          src_dz  [DW];
  logic [RW-1:0] nxt_rem [DW];
  logic [DW-1:0] nxt_dvd [DW];
  logic [DW-1:0] nxt_quo [DW];
  logic [RW-1:0] shifted;
  logic [TW-1:0] trial;

  always_comb begin
    shifted = '0;
    trial   = '0;
    src_vld[0] = in_valid;
    src_rem[0] = '0;
    src_dvd[0] = dividend;
    src_quo[0] = '0;
    src_dvs[0] = divisor;
    src_dz[0]  = (divisor == VW'(0));
    for (int k = 1; k < DW; k++) begin
      src_vld[k] = vld_q[k-1];
      src_rem[k] = rem_q[k-1];
      src_dvd[k] = dvd_q[k-1];
      src_quo[k] = quo_q[k-1];
      src_dvs[k] = dvs_q[k-1];
      src_dz[k]  = dz_q[k-1];
    end
    for (int k = 0; k < DW; k++) begin
      // Shift in the next dividend bit and trial-subtract; restore on borrow.
      shifted = {src_rem[k][VW-1:0], src_dvd[k][DW-1]};
      trial   = {1'b0, shifted} - {2'b00, src_dvs[k]};
      if (trial[TW-1]) begin
        nxt_rem[k] = shifted;
        nxt_quo[k] = {src_quo[k][DW-2:0], 1'b0};
      end else begin
        nxt_rem[k] = trial[RW-1:0];
        nxt_quo[k] = {src_quo[k][DW-2:0], 1'b1};
      end
      nxt_dvd[k] = {src_dvd[k][DW-2:0], 1'b0};
    end
  end

  // Intermediate stages: data may carry don't-cares under bubbles.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k] <= 1'b0;
        rem_q[k] <= '0;
        dvd_q[k] <= '0;
        quo_q[k] <= '0;
        dvs_q[k] <= '0;
        dz_q[k]  <= 1'b0;
      end
    end else if (en) begin
      for (int k = 0; k < NS; k++) begin
        vld_q[k] <= src_vld[k];
        rem_q[k] <= nxt_rem[k];
        dvd_q[k] <= nxt_dvd[k];
        quo_q[k] <= nxt_quo[k];
        dvs_q[k] <= src_dvs[k];
        dz_q[k]  <= src_dz[k];
      end
    end
  end

  // Output stage: result fields only load on a valid operation.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (en) begin
      out_valid <= src_vld[DW-1];
      if (src_vld[DW-1]) begin
        div_by_zero <= src_dz[DW-1];
        if (src_dz[DW-1]) begin
          quotient  <= '1;
          remainder <= '0;
        end else begin
          quotient  <= nxt_quo[DW-1];
          remainder <= nxt_rem[DW-1][VW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_array_divider.sv
// Directed bench for pipelined_array_divider: latency, edge values, dz, streaming, stall, reset, sweep.
module tb_pipelined_array_divider;

  localparam int unsigned DW = 8;
  localparam int unsigned VW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          in_valid;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_by_zero;

  int errors = 0;
  int checks = 0;

  pipelined_array_divider #(.DW(DW), .VW(VW)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .in_valid   (in_valid),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] a, input logic [VW-1:0] b);
    in_valid = v;
    dividend = a;
    divisor  = b;
  endtask

  task automatic check_res(input string tag, input logic [DW-1:0] q, input logic [VW-1:0] r,
                           input logic dz);
    check_eq({tag, ".valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, ".q"}, 32'(quotient), 32'(q));
    check_eq({tag, ".r"}, 32'(remainder), 32'(r));
    check_eq({tag, ".dz"}, 32'(div_by_zero), 32'(dz));
  endtask

  // One isolated operation; out_valid must stay low until exactly the 8th enabled edge.
  task automatic run_one(input string tag, input logic [DW-1:0] a, input logic [VW-1:0] b,
                         input logic [DW-1:0] q, input logic [VW-1:0] r, input logic dz);
    drive(1'b1, a, b);
    tick();
    drive(1'b0, '0, '0);
    check_eq({tag, ".lat1"}, 32'(out_valid), 32'd0);
    for (int c = 2; c < 8; c++) begin
      tick();
      check_eq({tag, ".lat"}, 32'(out_valid), 32'd0);
    end
    tick();
    check_res(tag, q, r, dz);
    tick();
    check_eq({tag, ".after"}, 32'(out_valid), 32'd0);
    check_eq({tag, ".hold_q"}, 32'(quotient), 32'(q));
  endtask

  logic [DW-1:0] s_a [4] = '{8'd200, 8'd100, 8'd17, 8'd0};
  logic [VW-1:0] s_b [4] = '{4'd7, 4'd3, 4'd4, 4'd5};
  logic [DW-1:0] s_q [4] = '{8'd28, 8'd33, 8'd4, 8'd0};
  logic [VW-1:0] s_r [4] = '{4'd4, 4'd1, 4'd1, 4'd0};

  logic [DW-1:0] exp_q [$];
  logic [VW-1:0] exp_r [$];
  logic          exp_z [$];

  initial begin
    rst = 1'b0;
    en  = 1'b1;
    drive(1'b0, '0, '0);
    tick();
    tick();
    check_eq("reset.valid", 32'(out_valid), 32'd0);
    check_eq("reset.q", 32'(quotient), 32'd0);
    check_eq("reset.r", 32'(remainder), 32'd0);
    check_eq("reset.dz", 32'(div_by_zero), 32'd0);
    rst = 1'b1;
    tick();

    run_one("basic", 8'd200, 4'd7, 8'd28, 4'd4, 1'b0);
    run_one("e255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0);
    run_one("e5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0);
    run_one("e255_1", 8'd255, 4'd1, 8'd255, 4'd0, 1'b0);
    run_one("dz", 8'h37, 4'd0, 8'hFF, 4'd0, 1'b1);

    // Back-to-back stream; results on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s_a[i], s_b[i]);
      tick();
    end
    drive(1'b0, '0, '0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("stream.gap", 32'(out_valid), 32'd0);
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      check_res("stream", s_q[i], s_r[i], 1'b0);
    end
    tick();
    check_eq("stream.end", 32'(out_valid), 32'd0);

    // Stall 3 cycles while the first result sits on the outputs; stall-time inputs are ignored.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s_a[i], s_b[i]);
      tick();
    end
    drive(1'b0, '0, '0);
    for (int i = 0; i < 4; i++) tick();
    check_res("stall.first", s_q[0], s_r[0], 1'b0);
    en = 1'b0;
    drive(1'b1, 8'd99, 4'd9);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_res("stall.frozen", s_q[0], s_r[0], 1'b0);
    end
    drive(1'b0, '0, '0);
    en = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      check_res("stall.resume", s_q[i], s_r[i], 1'b0);
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("stall.nodrop", 32'(out_valid), 32'd0);
    end

    // Reset with 4 operations in flight discards all of them.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, s_a[i], s_b[i]);
      tick();
    end
    drive(1'b0, '0, '0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check_eq("rst_mid.q", 32'(quotient), 32'd0);
    for (int i = 0; i < 12; i++) begin
      tick();
      check_eq("rst_mid.valid", 32'(out_valid), 32'd0);
    end
    run_one("post_rst", 8'd100, 4'd3, 8'd33, 4'd1, 1'b0);

    // Reset wins even with en=0.
    drive(1'b1, 8'd9, 4'd2);
    tick();
    drive(1'b0, '0, '0);
    en  = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    en  = 1'b1;
    check_eq("rst_noen.q", 32'(quotient), 32'd0);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("rst_noen.valid", 32'(out_valid), 32'd0);
    end

    // Exhaustive sweep against reference arithmetic, one operation per cycle.
    begin
      int got = 0;
      for (int i = 0; i < 4096 + 10; i++) begin
        if (i < 4096) begin
          logic [DW-1:0] a;
          logic [VW-1:0] b;
          a = DW'(i >> 4);
          b = VW'(i);
          drive(1'b1, a, b);
          if (b == 0) begin
            exp_q.push_back(8'hFF);
            exp_r.push_back(4'd0);
            exp_z.push_back(1'b1);
          end else begin
            exp_q.push_back(DW'(a / b));
            exp_r.push_back(VW'(a % b));
            exp_z.push_back(1'b0);
          end
        end else begin
          drive(1'b0, '0, '0);
        end
        tick();
        if (out_valid) begin
          got++;
          if (exp_q.size() == 0) begin
            check_eq("sweep.extra", 32'd1, 32'd0);
          end else begin
            logic [DW-1:0] eq;
            logic [VW-1:0] er;
            logic          ez;
            eq = exp_q.pop_front();
            er = exp_r.pop_front();
            ez = exp_z.pop_front();
            check_eq("sweep.q", 32'(quotient), 32'(eq));
            check_eq("sweep.r", 32'(remainder), 32'(er));
            check_eq("sweep.dz", 32'(div_by_zero), 32'(ez));
          end
        end
      end
      check_eq("sweep.count", 32'(got), 32'd4096);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_array_divider.md
Name: pipelined_array_divider

Overview:
- Fully pipelined restoring array divider: unsigned DW-bit dividend ÷ VW-bit divisor → DW-bit quotient, VW-bit remainder.
- Inverse datapath companion to the team's pipelined 4x4 array multiplier; the multiplier's 8-bit product range maps directly onto this divider's dividend.
- One quotient bit is resolved per pipeline stage. Throughput is one operation per enabled clock.

Parameters:
- DW, 8, dividend and quotient width; also the number of pipeline stages.
- VW, 4, divisor and remainder width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-low (clears when rst=0 at a clk edge)
- en  input  1  global advance enable; 0 freezes every pipeline register
- in_valid  input  1  dividend/divisor are valid this cycle
- dividend  input  DW  unsigned dividend
- divisor  input  VW  unsigned divisor
- out_valid  output  1  quotient/remainder/div_by_zero are valid this cycle
- quotient  output  DW  unsigned quotient
- remainder  output  VW  unsigned remainder
- div_by_zero  output  1  result belongs to an operation with divisor==0

Behaviour:
- Reset:
  - When rst=0 at a clk edge, all stage valid bits clear, out_valid=0, quotient=0, remainder=0, div_by_zero=0.
  - This applies regardless of en.
  - Reset mid-operation discards all in-flight operations; none emerge afterwards.
- Latency:
  - An operation accepted at enabled edge N (in_valid=1, en=1) presents its result with out_valid=1 after enabled edge N+DW-1. For DW=8 that is 8 enabled cycles, counting the capture edge.
  - Outputs are registered.
- Stage k (k=0..DW-1) resolves quotient bit DW-1-k:
  - Partial remainder r is VW+1 bits wide.
  - r' = {r[VW-1:0], next dividend MSB}.
  - Trial t = r' − {0,divisor}, computed VW+2 bits wide.
  - If t ≥ 0: q bit = 1, r = t. Otherwise q bit = 0, r = r' (restore).
  - Each stage registers: valid, partial remainder, unconsumed dividend bits, quotient bits so far, divisor, and the dz flag.
- Invariant: for every non-dz result, quotient*divisor + remainder == dividend and remainder < divisor.
- Divide by zero:
  - dz is captured at input (divisor==0) and carried down the pipe.
  - Output is forced to quotient = all ones (0xFF), remainder = 0, div_by_zero = 1, with out_valid=1 at normal latency.
- Bubbles:
  - in_valid=0 at an enabled edge inserts a bubble that propagates as out_valid=0.
  - Data registers may hold don't-care values under a bubble. quotient/remainder/div_by_zero must not change while out_valid=0; they hold their last valid result.
- Stall:
  - en=0 holds every register, including outputs and out_valid; inputs presented while en=0 are ignored.
  - Result ordering is strictly FIFO, with no reordering or drops.
- Simultaneous reset and en=1: reset wins.
- No backpressure input: the consumer must accept a result whenever out_valid=1 and en=1.

Test Plan:
- Basic: after reset, dividend=200, divisor=7, in_valid=1 for one cycle → exactly 8 enabled cycles later out_valid=1, quotient=28, remainder=4, div_by_zero=0; out_valid=0 in every other cycle.
- Edge values:
  - 255/15 → quotient=17, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 255/1 → quotient=255, remainder=0.
- Divide by zero: dividend=0x37, divisor=0 → quotient=0xFF, remainder=0, div_by_zero=1, same latency.
- Streaming: back-to-back inputs 200/7, 100/3, 17/4, 0/5 on consecutive cycles → results (28,4), (33,1), (4,1), (0,0) on consecutive cycles, in order.
- Stall and reset:
  - Pulse en=0 for 3 cycles mid-stream → outputs frozen and results delayed by exactly 3 cycles.
  - Separately, drive rst=0 for one edge with 4 operations in flight → out_valid stays 0 until new inputs propagate through the pipe.
- Exhaustive check: sweep all 256×16 dividend/divisor pairs streamed one per cycle → every non-dz result satisfies q*d+r==dividend and r<d; every d=0 case gives dz=1, q=0xFF, r=0.
